inst_encoder: RTL and testbench

RV32I instruction encoder: accepts decoded instruction fields (opcode, registers, funct fields, 32-bit signed immediate) over a valid/ready handshake and packs them into a 32-bit instruction word. It is the inverse of the immediate generator, and the encoding round-trips through it. The block sits between the test/boot program source and instruction memory. It emits one registered word per accepted field set, together with an auto-incrementing write address.

---
 rtl/inst_encoder_if.sv | 29 ++
 rtl/inst_encoder.sv | 118 +++++++++++
 tb/tb_inst_encoder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Field-set input and encoded-word output handshakes of the RV32I instruction encoder.
// master drives the decoded fields and out_ready; slave (the encoder) answers with the word.
interface inst_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr
    );
endinterface

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields into a 32-bit word with an auto-incrementing write address.
// Latency 1 cycle (word or err_pulse); single output register, in_ready = !out_valid || out_ready.
// Define IMM_RANGE_CHECK_EN to reject out-of-range or misaligned immediates.
module inst_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    inst_encoder_if.slave       bus,
    output logic                err_pulse,
    output logic [7:0]          err_count
);
    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_BAD
    } fmt_t;

    fmt_t              fmt;
    logic [31:0]       inst;
    logic              bad;
    logic              accept;
    logic              load;
    logic              rej;
    logic [ADDR_W-1:0] addr_cnt;

    logic [31:0] imm;
    assign imm = bus.in_imm;

    always_comb begin
        fmt = FMT_BAD;
        case (bus.in_opcode)
            7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
            7'b0100011:                         fmt = FMT_S;
            7'b1100011:                         fmt = FMT_B;
            7'b1101111:                         fmt = FMT_J;
            7'b0110011:                         fmt = FMT_R;
            default:                            fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        inst = '0;
        case (fmt)
            FMT_R: inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            FMT_I: inst = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            FMT_S: inst = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
            FMT_B: inst = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                           imm[4:1], imm[11], bus.in_opcode};
            FMT_J: inst = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            default: inst = '0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits in N signed bits when every bit above N-1 repeats the sign.
    logic fits12, fits13, fits21;
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: bad = !fits12;
            FMT_B:        bad = !fits13 || imm[0];
            FMT_J:        bad = !fits21 || imm[0];
            FMT_R:        bad = 1'b0;
            default:      bad = 1'b1;
        endcase
    end
`else
    assign bad = (fmt == FMT_BAD);
`endif

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign load         = accept && !bad;
    assign rej          = accept && bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_inst  <= '0;
            bus.out_addr  <= BASE_ADDR;
            addr_cnt      <= BASE_ADDR;
            err_pulse     <= 1'b0;
            err_count     <= '0;
        end else begin
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_inst  <= inst;
                bus.out_addr  <= addr_cnt;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            // start wins over the advance; the word taken this cycle already latched the old address
            if (start) begin
                addr_cnt <= BASE_ADDR;
            end else if (load) begin
                addr_cnt <= addr_cnt + ADDR_W'(4);
            end

            err_pulse <= rej;
            if (start) begin
                err_count <= rej ? 8'd1 : 8'd0;
            end else if (rej && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: ADDR_W=8 and BASE_ADDR=0xF0 so the address wrap is reachable.
module tb_inst_encoder;
    localparam int         AW   = 8;
    localparam logic [7:0] BASE = 8'hF0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       err_pulse;
    logic [7:0] err_count;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_addr;

    inst_encoder_if #(.ADDR_W(AW)) bus ();

    inst_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus.slave),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] jimm_decode(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    task automatic set_in(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] imm);
        bus.in_opcode = op;  bus.in_rd = rd;     bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_funct3 = f3;  bus.in_funct7 = f7; bus.in_imm = imm; bus.in_valid = 1'b1;
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_inst got=%h exp=0", bus.out_inst); end
        checks++; if (bus.out_addr !== BASE) begin errors++; $display("FAIL rst_out_addr got=%h exp=%h", bus.out_addr, BASE); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err_pulse got=%b exp=0", err_pulse); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        rst_n = 1'b1;
        exp_addr = BASE;
        @(negedge clk);
    endtask

    task automatic test_itype;
        // rs2/funct7 are junk: I-type must ignore them
        set_in(7'b0010011, 5'd1, 5'd0, 5'd5, 3'd0, 7'h7F, 32'd5);
        @(negedge clk); bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL itype_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_inst !== 32'h00500093) begin errors++; $display("FAIL itype_inst got=%h exp=00500093", bus.out_inst); end
        checks++; if (bus.out_addr !== exp_addr) begin errors++; $display("FAIL itype_addr got=%h exp=%h", bus.out_addr, exp_addr); end
        exp_addr = exp_addr + 8'd4;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL itype_drop got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_start;
        start = 1'b1; @(negedge clk); start = 1'b0;
        exp_addr = BASE;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL start_idle_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back;
        set_in(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        @(negedge clk);
        checks++; if (bus.out_inst !== 32'h0020A423) begin errors++; $display("FAIL stype_inst got=%h exp=0020A423", bus.out_inst); end
        checks++; if (bus.out_addr !== exp_addr) begin errors++; $display("FAIL stype_addr got=%h exp=%h", bus.out_addr, exp_addr); end
        exp_addr = exp_addr + 8'd4;
        set_in(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
        @(negedge clk); bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL btype_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_inst !== 32'hFE000EE3) begin errors++; $display("FAIL btype_inst got=%h exp=FE000EE3", bus.out_inst); end
        checks++; if (bus.out_addr !== exp_addr) begin errors++; $display("FAIL btype_addr got=%h exp=%h", bus.out_addr, exp_addr); end
        exp_addr = exp_addr + 8'd4;
    endtask

    task automatic test_jtype;
        set_in(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        @(negedge clk); bus.in_valid = 1'b0;
        checks++; if (bus.out_inst !== 32'h001000EF) begin errors++; $display("FAIL jtype_inst got=%h exp=001000EF", bus.out_inst); end
        checks++; if (jimm_decode(bus.out_inst) !== 32'd2048) begin errors++; $display("FAIL jtype_roundtrip got=%0d exp=2048", jimm_decode(bus.out_inst)); end
        checks++; if (bus.out_addr !== exp_addr) begin errors++; $display("FAIL jtype_addr got=%h exp=%h", bus.out_addr, exp_addr); end
        exp_addr = exp_addr + 8'd4;
    endtask

    task automatic test_rtype_wrap;
        // sub x3,x1,x2 lands on the last address before the 8-bit counter wraps
        set_in(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 32'hFFFF_FFFF);
        @(negedge clk); bus.in_valid = 1'b0;
        checks++; if (bus.out_inst !== 32'h402081B3) begin errors++; $display("FAIL rtype_inst got=%h exp=402081B3", bus.out_inst); end
        checks++; if (bus.out_addr !== 8'hFC) begin errors++; $display("FAIL rtype_addr got=%h exp=fc", bus.out_addr); end
        exp_addr = exp_addr + 8'd4;
        set_in(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk); bus.in_valid = 1'b0;
        checks++; if (bus.out_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr got=%h exp=00", bus.out_addr); end
        checks++; if (bus.out_inst !== 32'h00100113) begin errors++; $display("FAIL wrap_inst got=%h exp=00100113", bus.out_inst); end
        exp_addr = exp_addr + 8'd4;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        set_in(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        @(negedge clk);
        set_in(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.out_inst !== 32'h00700213 || bus.out_addr !== exp_addr || bus.out_valid !== 1'b1)
                begin errors++; $display("FAIL bp_hold%0d got=%h@%h exp=00700213@%h", k, bus.out_inst, bus.out_addr, exp_addr); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got=%b exp=0", k, bus.in_ready); end
            @(negedge clk);
        end
        checks++; if (bus.out_inst !== 32'h00700213) begin errors++; $display("FAIL bp_hold_end got=%h exp=00700213", bus.out_inst); end
        bus.out_ready = 1'b1;
        exp_addr = exp_addr + 8'd4;
        @(negedge clk); bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h00900293) begin errors++; $display("FAIL bp_second_inst got=%h exp=00900293", bus.out_inst); end
        checks++; if (bus.out_addr !== exp_addr) begin errors++; $display("FAIL bp_second_addr got=%h exp=%h", bus.out_addr, exp_addr); end
        exp_addr = exp_addr + 8'd4;
        @(negedge clk);
    endtask

    task automatic test_errors;
`ifdef IMM_RANGE_CHECK_EN
        set_in(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        @(negedge clk);
        checks++; if (err_pulse !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL err_i_range got pulse=%b valid=%b exp 1/0", err_pulse, bus.out_valid); end
        set_in(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        @(negedge clk);
        checks++; if (err_pulse !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL err_b_align got pulse=%b valid=%b exp 1/0", err_pulse, bus.out_valid); end
        set_in(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        @(negedge clk); bus.in_valid = 1'b0;
        checks++; if (err_pulse !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL err_opcode got pulse=%b valid=%b exp 1/0", err_pulse, bus.out_valid); end
        checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL err_count3 got=%0d exp=3", err_count); end
        start = 1'b1; @(negedge clk); start = 1'b0;
        checks++; if (err_count !== 8'd0 || err_pulse !== 1'b0) begin errors++; $display("FAIL err_start_clear got cnt=%0d pulse=%b exp 0/0", err_count, err_pulse); end
        exp_addr = BASE;
        set_in(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
        @(negedge clk); bus.in_valid = 1'b0;
        checks++; if (bus.out_inst !== 32'h80000013 || bus.out_addr !== exp_addr) begin errors++; $display("FAIL imm_min_ok got=%h@%h exp=80000013@%h", bus.out_inst, bus.out_addr, exp_addr); end
        exp_addr = exp_addr + 8'd4;
`else
        set_in(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        @(negedge clk); bus.in_valid = 1'b0;
        checks++; if (err_pulse !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL err_opcode got pulse=%b valid=%b exp 1/0", err_pulse, bus.out_valid); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL err_count1 got=%0d exp=1", err_count); end
        @(negedge clk);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL err_pulse_width got=%b exp=0", err_pulse); end
        // unchecked build: B imm bit 0 silently dropped, I imm truncated
        set_in(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        @(negedge clk);
        checks++; if (bus.out_inst !== 32'h00000163 || bus.out_addr !== exp_addr) begin errors++; $display("FAIL b_trunc got=%h@%h exp=00000163@%h", bus.out_inst, bus.out_addr, exp_addr); end
        exp_addr = exp_addr + 8'd4;
        set_in(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        @(negedge clk); bus.in_valid = 1'b0;
        checks++; if (bus.out_inst !== 32'h80000013 || bus.out_addr !== exp_addr) begin errors++; $display("FAIL i_trunc got=%h@%h exp=80000013@%h", bus.out_inst, bus.out_addr, exp_addr); end
        exp_addr = exp_addr + 8'd4;
`endif
        @(negedge clk);
    endtask

    task automatic test_start_same_cycle;
        set_in(7'b0010011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (bus.out_addr !== exp_addr) begin errors++; $display("FAIL start_same_addr got=%h exp=%h", bus.out_addr, exp_addr); end
        exp_addr = BASE;
        set_in(7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk);
        checks++; if (bus.out_addr !== BASE || bus.out_inst !== 32'h00100393) begin errors++; $display("FAIL start_next got=%h@%h exp=00100393@%h", bus.out_inst, bus.out_addr, BASE); end
        exp_addr = exp_addr + 8'd4;
        set_in(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        start = 1'b1;
        @(negedge clk); start = 1'b0; bus.in_valid = 1'b0;
        checks++; if (err_count !== 8'd1 || err_pulse !== 1'b1) begin errors++; $display("FAIL start_err got cnt=%0d pulse=%b exp 1/1", err_count, err_pulse); end
        exp_addr = BASE;
        @(negedge clk);
    endtask

    task automatic test_saturate;
        set_in(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (260) @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate got=%0d exp=255", err_count); end
        set_in(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk); bus.in_valid = 1'b0;
        checks++; if (bus.out_addr !== exp_addr) begin errors++; $display("FAIL err_addr_hold got=%h exp=%h", bus.out_addr, exp_addr); end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        bus.out_ready = 1'b0;
        set_in(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk); bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL async_rst got valid=%b cnt=%0d exp 0/0", bus.out_valid, err_count); end
        @(negedge clk); rst_n = 1'b1; bus.out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_itype();
        test_start();
        test_back_to_back();
        test_jtype();
        test_rtype_wrap();
        test_backpressure();
        test_errors();
        test_start_same_cycle();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
